// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector run controller.
//   state_t       : run-controller FSM encoding
//   N/CW/TW_DEF   : default pattern length, match-count width, timeout width
//   fill_width()  : width of a fill counter that saturates at n
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned CW_DEF = 8;
    localparam int unsigned TW_DEF = 16;

    function automatic int unsigned fill_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned FILL_W_DEF = $clog2(N_DEF + 1);

endpackage

// File: rtl/seq_det_core.sv
// Shift history, warm-up fill counter and pattern compare.
//   clk, rstn : clock, async active-low reset
//   clr       : clear history and fill (run start)
//   en        : sample bit_i into the history
//   bit_i     : serial data bit
//   pattern   : pattern to match, MSB oldest
//   match_o   : the history/fill about to be registered form a match
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_i,
    input  logic [N-1:0] pattern,
    output logic         match_o
);

    localparam int unsigned FW = fill_width(N);

    logic [N-1:0]  hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = {hist_q[N-2:0], bit_i};
            if (fill_q != FW'(N)) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Fill gate keeps a reset history of zeros from matching an all-zero
    // pattern before N real bits have been seen.
    assign match_o = en && !clr && (hist_d == pattern) && (fill_d == FW'(N));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for a programmable N-bit serial pattern detector.
//   clk, rstn        : clock, async active-low reset
//   cfg_valid/ready  : config handshake (accepted only in IDLE)
//   cfg_pattern      : pattern, MSB oldest
//   cfg_count        : matches needed to finish (0 = unlimited)
//   cfg_timeout      : run length in cycles (0 = none)
//   start, abort     : arm request, cancel current run
//   xin_valid, xin   : qualified serial bit stream
//   det_o            : one-cycle pulse per match
//   match_cnt        : matches in the current or last run
//   busy             : run in progress
//   done_o           : one-cycle end-of-run pulse
//   timeout_o        : last run ended by timeout
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [N-1:0]  cfg_pattern,
    input  logic [CW-1:0] cfg_count,
    input  logic [TW-1:0] cfg_timeout,
    input  logic          start,
    input  logic          abort,
    input  logic          xin_valid,
    input  logic          xin,
    output logic          det_o,
    output logic [CW-1:0] match_cnt,
    output logic          busy,
    output logic          done_o,
    output logic          timeout_o
);

    state_t        state_q, state_d;
    logic [N-1:0]  pat_q, pat_d;
    logic [CW-1:0] cnt_cfg_q, cnt_cfg_d;
    logic [TW-1:0] tmo_cfg_q, tmo_cfg_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic          det_q, det_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;

    logic core_clr;
    logic core_en;
    logic core_match;
    logic hit;
    logic reach;
    logic expire;

    seq_det_core #(
        .N(N)
    ) u_core (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (core_clr),
        .en      (core_en),
        .bit_i   (xin),
        .pattern (pat_q),
        .match_o (core_match)
    );

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        cnt_cfg_d   = cnt_cfg_q;
        tmo_cfg_d   = tmo_cfg_q;
        timer_d     = timer_q;
        match_cnt_d = match_cnt_q;
        timeout_d   = timeout_q;
        det_d       = 1'b0;
        done_d      = 1'b0;
        core_clr    = 1'b0;
        core_en     = 1'b0;
        hit         = 1'b0;
        reach       = 1'b0;
        expire      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    pat_d     = cfg_pattern;
                    cnt_cfg_d = cfg_count;
                    tmo_cfg_d = cfg_timeout;
                end
                if (start) begin
                    state_d     = ARMED;
                    core_clr    = 1'b1;
                    match_cnt_d = '0;
                    timer_d     = '0;
                    timeout_d   = 1'b0;
                end
            end
            ARMED: begin
                core_en = xin_valid;
                timer_d = timer_q + TW'(1);
                // abort suppresses the match of a bit sampled on the same edge
                hit     = core_match && !abort;
                if (hit && (match_cnt_q != '1)) begin
                    match_cnt_d = match_cnt_q + CW'(1);
                end
                reach  = hit && (cnt_cfg_q != '0) && (match_cnt_d == cnt_cfg_q);
                expire = (tmo_cfg_q != '0) && (timer_q == tmo_cfg_q - TW'(1));
                det_d  = hit;
                if (abort) begin
                    state_d = IDLE;
                end else if (reach || expire) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    // reaching the target wins over a coincident expiry
                    timeout_d = !reach;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            cnt_cfg_q   <= '0;
            tmo_cfg_q   <= '0;
            timer_q     <= '0;
            match_cnt_q <= '0;
            det_q       <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            cnt_cfg_q   <= cnt_cfg_d;
            tmo_cfg_q   <= tmo_cfg_d;
            timer_q     <= timer_d;
            match_cnt_q <= match_cnt_d;
            det_q       <= det_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign det_o     = det_q;
    assign done_o    = done_q;
    assign match_cnt = match_cnt_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: a behavioural model pushes the
// expected post-edge outputs per driven cycle; a monitor pops and compares.
module tb_seq_det_ctrl;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int TW = 16;

    localparam int ST_IDLE  = 0;
    localparam int ST_ARMED = 1;
    localparam int ST_DONE  = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [N-1:0]  cfg_pattern;
    logic [CW-1:0] cfg_count;
    logic [TW-1:0] cfg_timeout;
    logic          start;
    logic          abort;
    logic          xin_valid;
    logic          xin;
    logic          det_o;
    logic [CW-1:0] match_cnt;
    logic          busy;
    logic          done_o;
    logic          timeout_o;

    seq_det_ctrl #(
        .N (N),
        .CW(CW),
        .TW(TW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_count  (cfg_count),
        .cfg_timeout(cfg_timeout),
        .start      (start),
        .abort      (abort),
        .xin_valid  (xin_valid),
        .xin        (xin),
        .det_o      (det_o),
        .match_cnt  (match_cnt),
        .busy       (busy),
        .done_o     (done_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          det;
        logic          done;
        logic          busy;
        logic          ready;
        logic [CW-1:0] cnt;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int checks    = 0;
    int failures  = 0;
    int det_seen  = 0;
    int done_seen = 0;

    int          m_st;
    int unsigned m_hist, m_nbits, m_cnt, m_timer, m_pat, m_cc, m_tm;
    logic        m_to;

    task automatic model_reset();
        m_st = ST_IDLE; m_hist = 0; m_nbits = 0; m_cnt = 0; m_timer = 0;
        m_pat = 0; m_cc = 0; m_tm = 0; m_to = 1'b0;
    endtask

    // Drive one cycle, predict the outputs after the edge, advance past it.
    task automatic tick(input logic cv, input logic st, input logic ab,
                        input logic xv, input logic x);
        exp_t e;
        logic hit, fin_c, fin_t;
        int unsigned max_cnt = (1 << CW) - 1;
        cfg_valid = cv; start = st; abort = ab; xin_valid = xv; xin = x;
        hit = 1'b0; fin_c = 1'b0; fin_t = 1'b0; e.done = 1'b0;
        case (m_st)
            ST_IDLE: begin
                if (cv) begin
                    m_pat = cfg_pattern; m_cc = cfg_count; m_tm = cfg_timeout;
                end
                if (st) begin
                    m_st = ST_ARMED; m_hist = 0; m_nbits = 0;
                    m_cnt = 0; m_timer = 0; m_to = 1'b0;
                end
            end
            ST_ARMED: begin
                if (xv) begin
                    m_hist = ((m_hist << 1) | int'(x)) & ((1 << N) - 1);
                    m_nbits++;
                end
                hit = xv && !ab && (m_nbits >= N) && (m_hist == m_pat);
                if (ab) begin
                    m_st = ST_IDLE;
                end else begin
                    if (hit && m_cnt < max_cnt) m_cnt++;
                    fin_c = hit && (m_cc != 0) && (m_cnt == m_cc);
                    m_timer++;
                    fin_t = (m_tm != 0) && (m_timer == m_tm);
                    if (fin_c || fin_t) begin
                        m_st = ST_DONE; e.done = 1'b1; m_to = fin_t && !fin_c;
                    end
                end
            end
            default: m_st = ST_IDLE;
        endcase
        e.det = hit; e.busy = (m_st != ST_IDLE); e.ready = (m_st == ST_IDLE);
        e.cnt = m_cnt[CW-1:0]; e.to = m_to;
        exp_q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (det_o !== e.det) begin failures++; $display("FAIL sb_det got=%b exp=%b t=%0t", det_o, e.det, $time); end
            checks++; if (done_o !== e.done) begin failures++; $display("FAIL sb_done got=%b exp=%b t=%0t", done_o, e.done, $time); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL sb_busy got=%b exp=%b t=%0t", busy, e.busy, $time); end
            checks++; if (cfg_ready !== e.ready) begin failures++; $display("FAIL sb_ready got=%b exp=%b t=%0t", cfg_ready, e.ready, $time); end
            checks++; if (match_cnt !== e.cnt) begin failures++; $display("FAIL sb_cnt got=%0d exp=%0d t=%0t", match_cnt, e.cnt, $time); end
            checks++; if (timeout_o !== e.to) begin failures++; $display("FAIL sb_to got=%b exp=%b t=%0t", timeout_o, e.to, $time); end
            if (det_o === 1'b1) det_seen++;
            if (done_o === 1'b1) done_seen++;
        end
    end

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cfg_ready); end
        checks++; if (det_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", det_o, done_o); end
        checks++; if (match_cnt !== '0 || timeout_o !== 1'b0) begin failures++; $display("FAIL rst_status got=%0d/%b exp=0/0", match_cnt, timeout_o); end
        #10 rstn = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", cfg_ready); end
        model_reset();
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1011011;
        cfg_pattern = 4'b1011; cfg_count = '0; cfg_timeout = '0;
        det_seen = 0; done_seen = 0;
        tick(1, 1, 0, 0, 0);
        // a start during ARMED must be ignored
        for (int i = 0; i < 7; i++) tick(0, (i == 4), 0, 1, s[6-i]);
        checks++; if (det_seen != 2) begin failures++; $display("FAIL ovl_dets got=%0d exp=2", det_seen); end
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL ovl_cnt got=%0d exp=2", match_cnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovl_busy got=%b exp=1", busy); end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL ovl_done got=%0d exp=0", done_seen); end
        tick(0, 0, 1, 0, 0);
        checks++; if (busy !== 1'b0 || match_cnt !== 8'd2) begin failures++; $display("FAIL ovl_abort got=%b/%0d exp=0/2", busy, match_cnt); end
    endtask

    task automatic test_target();
        logic [6:0] s = 7'b1011011;
        cfg_pattern = 4'b1011; cfg_count = 8'd2; cfg_timeout = '0;
        det_seen = 0; done_seen = 0;
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 0, 1, s[6-i]);
        checks++; if (det_o !== 1'b1 || done_o !== 1'b1) begin failures++; $display("FAIL tgt_coincide got=%b%b exp=11", det_o, done_o); end
        tick(0, 0, 0, 0, 0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tgt_busy got=%b exp=0", busy); end
        checks++; if (timeout_o !== 1'b0 || match_cnt !== 8'd2) begin failures++; $display("FAIL tgt_status got=%b/%0d exp=0/2", timeout_o, match_cnt); end
        checks++; if (done_seen != 1) begin failures++; $display("FAIL tgt_done_cnt got=%0d exp=1", done_seen); end
    endtask

    task automatic test_timeout();
        int n = 0;
        cfg_pattern = 4'b1011; cfg_count = 8'd1; cfg_timeout = 16'd10;
        tick(1, 1, 0, 0, 0);
        while (done_o !== 1'b1 && n < 20) begin
            tick(0, 0, 0, 1, 0);
            n++;
        end
        checks++; if (n != 10) begin failures++; $display("FAIL tmo_latency got=%0d exp=10", n); end
        checks++; if (timeout_o !== 1'b1 || match_cnt !== '0) begin failures++; $display("FAIL tmo_status got=%b/%0d exp=1/0", timeout_o, match_cnt); end
        tick(0, 0, 0, 0, 0);
        checks++; if (busy !== 1'b0 || timeout_o !== 1'b1) begin failures++; $display("FAIL tmo_hold got=%b/%b exp=0/1", busy, timeout_o); end
    endtask

    task automatic test_gaps();
        cfg_pattern = 4'b1111; cfg_count = '0; cfg_timeout = '0;
        det_seen = 0;
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 1);
        checks++; if (det_seen != 0) begin failures++; $display("FAIL gap_early got=%0d exp=0", det_seen); end
        tick(0, 0, 0, 1, 1);
        checks++; if (det_o !== 1'b1 || det_seen != 1) begin failures++; $display("FAIL gap_fourth got=%b/%0d exp=1/1", det_o, det_seen); end
        tick(0, 0, 1, 0, 0);
        cfg_pattern = 4'b0000;
        det_seen = 0;
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
        checks++; if (det_seen != 0) begin failures++; $display("FAIL warm_early got=%0d exp=0", det_seen); end
        tick(0, 0, 0, 1, 0);
        checks++; if (det_o !== 1'b1) begin failures++; $display("FAIL warm_fourth got=%b exp=1", det_o); end
        tick(0, 0, 1, 0, 0);
    endtask

    task automatic test_abort_restart();
        logic [3:0] s = 4'b1011;
        logic [3:0] s2 = 4'b0110;
        cfg_pattern = 4'b1011; cfg_count = '0; cfg_timeout = '0;
        done_seen = 0;
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, s[3-i]);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 1);
        checks++; if (busy !== 1'b0 || match_cnt !== 8'd1) begin failures++; $display("FAIL abt_state got=%b/%0d exp=0/1", busy, match_cnt); end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL abt_done got=%0d exp=0", done_seen); end
        cfg_pattern = 4'b0110;
        tick(1, 0, 0, 0, 0);
        checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL abt_cfg_hold got=%0d exp=1", match_cnt); end
        tick(0, 1, 0, 0, 0);
        checks++; if (match_cnt !== '0 || busy !== 1'b1) begin failures++; $display("FAIL abt_restart got=%0d/%b exp=0/1", match_cnt, busy); end
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, s2[3-i]);
        checks++; if (det_o !== 1'b1) begin failures++; $display("FAIL abt_newpat got=%b exp=1", det_o); end
        tick(0, 0, 1, 0, 0);
    endtask

    task automatic test_lockout_reset();
        logic [3:0] s = 4'b1011;
        cfg_pattern = 4'b1011; cfg_count = '0; cfg_timeout = '0;
        tick(1, 1, 0, 0, 0);
        cfg_pattern = 4'b0000; cfg_count = 8'd1;
        tick(1, 0, 0, 0, 0);
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL lock_ready got=%b exp=0", cfg_ready); end
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 1, s[3-i]);
        checks++; if (det_o !== 1'b1 || busy !== 1'b1 || done_o !== 1'b0) begin failures++; $display("FAIL lock_cfg got=%b%b%b exp=110", det_o, busy, done_o); end
        cfg_valid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || det_o !== 1'b0) begin failures++; $display("FAIL mrst_busy_det got=%b%b exp=00", busy, det_o); end
        checks++; if (match_cnt !== '0 || timeout_o !== 1'b0) begin failures++; $display("FAIL mrst_status got=%0d/%b exp=0/0", match_cnt, timeout_o); end
        model_reset();
        #2 rstn = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mrst_release got=%b/%b exp=1/0", cfg_ready, busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_count = '0;
        cfg_timeout = '0; start = 1'b0; abort = 1'b0; xin_valid = 1'b0; xin = 1'b0;
        model_reset();
        test_reset();
        test_overlap();
        test_target();
        test_timeout();
        test_gaps();
        test_abort_restart();
        test_lockout_reset();
        tick(0, 0, 0, 0, 0);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
